// File: rtl/cursor_overlay_if.sv
// cursor_overlay_if: pixel stream in from the tile generator and out toward the palette stage
interface cursor_overlay_if;
    logic [7:0] IN_data;
    logic       IN_wrreq;
    logic       IN_wrfull;
    logic [7:0] OUT_data;
    logic       OUT_wrreq;
    logic       OUT_wrfull;
    modport slave (input IN_data, IN_wrreq, OUT_wrfull, output IN_wrfull, OUT_data, OUT_wrreq);
    modport master (output IN_data, IN_wrreq, OUT_wrfull, input IN_wrfull, OUT_data, OUT_wrreq);
endinterface

// File: rtl/cursor_overlay.sv
// cursor_overlay: 16x16 2-bit hardware cursor merged into the pixel stream via an output + skid register.
// Define CURSOR_INVERT_EN to make cursor code 3 invert the underlying pixel instead of using CUR_COLOR1.
module cursor_overlay #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480
) (
    input  logic                   MemClk,
    input  logic                   Reset,
    input  logic                   ScreenStop,
    cursor_overlay_if.slave        bus,
    input  logic                   CUR_enable,
    input  logic [10:0]            CUR_X,
    input  logic [10:0]            CUR_Y,
    input  logic [7:0]             CUR_COLOR1,
    input  logic [7:0]             CUR_COLOR2,
    input  logic [3:0]             CUR_wraddress,
    input  logic [31:0]            CUR_data,
    input  logic                   CUR_wren,
    output logic                   OVF
);
    logic [10:0] x_q, x_d, y_q, y_d;
    logic [7:0]  out_q, out_d, skid_q, skid_d;
    logic        out_v_q, out_v_d, skid_v_q, skid_v_d, ovf_q, ovf_d;
    logic [31:0] bitmap_q [16];
    logic [31:0] bitmap_d [16];
    logic [11:0] dx, dy;
    logic [31:0] row;
    logic [1:0]  code;
    logic [7:0]  inv, pix;
    logic        hit, acc, drain, x_end;

    assign bus.OUT_wrreq = out_v_q & ~bus.OUT_wrfull & ~ScreenStop & ~Reset;
    assign bus.IN_wrfull = skid_v_q & ~ScreenStop;
    assign bus.OUT_data  = out_q;
    assign OVF           = ovf_q;

    // 12-bit offsets: a cursor near 2047 can never alias back onto the screen
    always_comb begin
        dx   = {1'b0, x_q} - {1'b0, CUR_X};
        dy   = {1'b0, y_q} - {1'b0, CUR_Y};
        hit  = CUR_enable && x_q >= CUR_X && dx < 12'd16 && y_q >= CUR_Y && dy < 12'd16;
        row  = bitmap_q[dy[3:0]];
        code = row[{dx[3:0], 1'b0} +: 2];
`ifdef CURSOR_INVERT_EN
        inv  = ~bus.IN_data;
`else
        inv  = CUR_COLOR1;
`endif
        pix  = (!hit || code == 2'd0) ? bus.IN_data :
               code == 2'd1 ? CUR_COLOR1 :
               code == 2'd2 ? CUR_COLOR2 : inv;
    end

    always_comb begin
        bitmap_d = bitmap_q;
        if (CUR_wren) bitmap_d[CUR_wraddress] = CUR_data;
        acc      = bus.IN_wrreq & ~skid_v_q & ~ScreenStop;
        drain    = bus.OUT_wrreq;
        x_end    = x_q == 11'(H_ACTIVE - 1);
        x_d      = ScreenStop ? 11'd0 : !acc ? x_q : x_end ? 11'd0 : x_q + 11'd1;
        y_d      = ScreenStop ? 11'd0 : !(acc && x_end) ? y_q :
                   y_q == 11'(V_ACTIVE - 1) ? 11'd0 : y_q + 11'd1;
        ovf_d    = ovf_q | (bus.IN_wrreq & skid_v_q & ~ScreenStop);
        // an empty or draining output register takes the skid first, which keeps order
        out_v_d  = (!out_v_q || drain) ? (skid_v_q | acc) : 1'b1;
        out_d    = (!out_v_q || drain) ? (skid_v_q ? skid_q : acc ? pix : out_q) : out_q;
        skid_v_d = (!out_v_q || drain) ? 1'b0 : (skid_v_q | acc);
        skid_d   = (out_v_q && !drain && acc) ? pix : skid_q;
        if (ScreenStop) begin
            out_v_d  = 1'b0;
            skid_v_d = 1'b0;
        end
    end

    always_ff @(posedge MemClk) begin
        bitmap_q <= bitmap_d;
        skid_q   <= skid_d;
        if (Reset) begin
            x_q      <= '0;
            y_q      <= '0;
            out_q    <= '0;
            out_v_q  <= 1'b0;
            skid_v_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            x_q      <= x_d;
            y_q      <= y_d;
            out_q    <= out_d;
            out_v_q  <= out_v_d;
            skid_v_q <= skid_v_d;
            ovf_q    <= ovf_d;
        end
    end
endmodule

// File: tb/tb_cursor_overlay.sv
// tb_cursor_overlay: directed spot checks plus randomized traffic against a queue-based reference model.
module tb_cursor_overlay;
    localparam int H = 640;
    localparam int V = 480;
    logic        MemClk = 0, Reset = 1, ScreenStop = 0, CUR_enable = 0, CUR_wren = 0, OVF;
    logic [10:0] CUR_X = 0, CUR_Y = 0;
    logic [7:0]  CUR_COLOR1 = 0, CUR_COLOR2 = 0;
    logic [3:0]  CUR_wraddress = 0;
    logic [31:0] CUR_data = 0;
    int          total = 0, bad = 0;
    bit          run = 0, m_ovf = 0;
    int          mx = 0, my = 0;
    logic [7:0]  q[$];
    logic [7:0]  got[$];
    logic [31:0] m_bm [16];

    cursor_overlay_if bus();

    cursor_overlay #(.H_ACTIVE(H), .V_ACTIVE(V)) dut (
        .MemClk(MemClk), .Reset(Reset), .ScreenStop(ScreenStop), .bus(bus),
        .CUR_enable(CUR_enable), .CUR_X(CUR_X), .CUR_Y(CUR_Y),
        .CUR_COLOR1(CUR_COLOR1), .CUR_COLOR2(CUR_COLOR2),
        .CUR_wraddress(CUR_wraddress), .CUR_data(CUR_data), .CUR_wren(CUR_wren), .OVF(OVF)
    );

    always #5 MemClk = ~MemClk;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s got=%h expected=%h t=%0t", n, a, e, $time);
        end
    endtask

    function automatic logic [7:0] model_pix(input logic [7:0] d);
        int c;
        if (!CUR_enable || mx < int'(CUR_X) || mx >= int'(CUR_X) + 16 ||
            my < int'(CUR_Y) || my >= int'(CUR_Y) + 16) return d;
        c = int'((m_bm[my - int'(CUR_Y)] >> (2 * (mx - int'(CUR_X)))) & 32'd3);
        if (c == 0) return d;
        if (c == 1) return CUR_COLOR1;
        if (c == 2) return CUR_COLOR2;
`ifdef CURSOR_INVERT_EN
        return d ^ 8'hFF;
`else
        return CUR_COLOR1;
`endif
    endfunction

    // Model: DUT holds q.size() pixels; output reg valid iff >=1, skid valid iff ==2
    always @(negedge MemClk) if (run) begin
        int  n;
        bit  exp_req;
        exp_req = !Reset && !ScreenStop && q.size() > 0 && !bus.OUT_wrfull;
        chk("OUT_wrreq", 32'(bus.OUT_wrreq), 32'(exp_req));
        chk("IN_wrfull", 32'(bus.IN_wrfull), 32'(!ScreenStop && q.size() == 2));
        chk("OVF", 32'(OVF), 32'(m_ovf));
        if (exp_req && bus.OUT_wrreq) chk("OUT_data", 32'(bus.OUT_data), 32'(q[0]));
        if (bus.OUT_wrreq) got.push_back(bus.OUT_data);
        if (Reset) begin
            q.delete(); mx = 0; my = 0; m_ovf = 0;
        end else if (ScreenStop) begin
            q.delete(); mx = 0; my = 0;
        end else begin
            n = q.size();
            if (n > 0 && !bus.OUT_wrfull) void'(q.pop_front());
            if (bus.IN_wrreq) begin
                if (n < 2) begin
                    q.push_back(model_pix(bus.IN_data));
                    if (mx == H - 1) begin
                        mx = 0;
                        my = (my == V - 1) ? 0 : my + 1;
                    end else mx++;
                end else m_ovf = 1;
            end
        end
        if (CUR_wren) m_bm[CUR_wraddress] = CUR_data;
    end

    task automatic tick();
        @(posedge MemClk);
        #1;
    endtask

    task automatic send(input logic [7:0] d);
        int n = 0;
        tick();
        while (bus.IN_wrfull) begin
            bus.IN_wrreq = 0;
            if (++n > 100) begin
                chk("send_timeout", 32'(bus.IN_wrfull), 32'd0);
                return;
            end
            tick();
        end
        bus.IN_wrreq = 1;
        bus.IN_data  = d;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            tick();
            bus.IN_wrreq = 0;
        end
    endtask

    task automatic wrow(input logic [3:0] a, input logic [31:0] d);
        tick();
        bus.IN_wrreq = 0;
        CUR_wren = 1; CUR_wraddress = a; CUR_data = d;
        tick();
        CUR_wren = 0;
    endtask

    task automatic stop();
        tick();
        bus.IN_wrreq = 0;
        ScreenStop = 1;
        tick();
        ScreenStop = 0;
    endtask

    task automatic pulse_reset();
        tick();
        bus.IN_wrreq = 0;
        Reset = 1;
        tick();
        Reset = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad + 1);
        $fatal(1);
    end

    initial begin
        int c;
        for (int i = 0; i < 16; i++) m_bm[i] = 0;
        bus.IN_data = 0; bus.IN_wrreq = 0; bus.OUT_wrfull = 0;
        tick(); tick();
        run = 1;
        Reset = 0;
        chk("rst_OUT_data", 32'(bus.OUT_data), 32'h00);
        chk("rst_OUT_wrreq", 32'(bus.OUT_wrreq), 32'd0);
        chk("rst_IN_wrfull", 32'(bus.IN_wrfull), 32'd0);
        chk("rst_OVF", 32'(OVF), 32'd0);
        for (int i = 0; i < 16; i++) wrow(4'(i), 32'h0);

        // Pass-through line, one cycle of latency
        got.delete();
        send(8'h10);
        @(negedge MemClk);
        chk("lat_first_cycle", 32'(bus.OUT_wrreq), 32'd0);
        send(8'h10);
        @(negedge MemClk);
        chk("lat_next_cycle", 32'(bus.OUT_wrreq), 32'd1);
        chk("lat_data", 32'(bus.OUT_data), 32'h10);
        for (int i = 2; i < H; i++) send(8'h10);
        idle(3);
        c = 0;
        foreach (got[i]) if (got[i] == 8'h10) c++;
        chk("line_count", 32'(got.size()), 32'd640);
        chk("line_all_10", 32'(c), 32'd640);

        // Bitmap survives reset; single code-1 pixel at (0,0)
        wrow(0, 32'h1);
        pulse_reset();
        CUR_X = 0; CUR_Y = 0; CUR_COLOR1 = 8'hA5; CUR_enable = 1;
        got.delete();
        for (int i = 0; i < 4; i++) send(8'h10);
        idle(3);
        chk("c1_px0", 32'(got[0]), 32'hA5);
        chk("c1_px1", 32'(got[1]), 32'h10);
        chk("c1_px3", 32'(got[3]), 32'h10);

        // Right-edge clipping across 17 lines
        stop();
        for (int i = 0; i < 16; i++) wrow(4'(i), 32'h55555555);
        CUR_X = 11'd632; CUR_COLOR1 = 8'h22;
        got.delete();
        for (int i = 0; i < H * 17; i++) send(8'h10);
        idle(3);
        c = 0;
        foreach (got[i]) if (got[i] == 8'h22) c++;
        chk("clip_count", 32'(c), 32'd128);
        chk("clip_632", 32'(got[632]), 32'h22);
        chk("clip_631", 32'(got[631]), 32'h10);
        chk("clip_l15_639", 32'(got[15 * H + 639]), 32'h22);
        chk("clip_l16_632", 32'(got[16 * H + 632]), 32'h10);
        chk("clip_l1_0", 32'(got[H]), 32'h10);

        // Backpressure and skid ordering
        stop();
        CUR_enable = 0;
        got.delete();
        bus.OUT_wrfull = 1;
        send(8'd1);
        send(8'd2);
        idle(1);
        chk("skid_full", 32'(bus.IN_wrfull), 32'd1);
        bus.OUT_wrfull = 0;
        send(8'd3);
        send(8'd4);
        idle(4);
        chk("bp_count", 32'(got.size()), 32'd4);
        for (int i = 0; i < 4; i++) chk("bp_order", 32'(got[i]), 32'(i + 1));
        chk("bp_ovf", 32'(OVF), 32'd0);

        // Code 3
        stop();
        wrow(0, 32'h3);
        CUR_X = 0; CUR_COLOR1 = 8'h5A; CUR_enable = 1;
        got.delete();
        send(8'h0F);
        idle(3);
`ifdef CURSOR_INVERT_EN
        chk("code3", 32'(got[0]), 32'hF0);
`else
        chk("code3", 32'(got[0]), 32'h5A);
`endif

        // Overflow on write while full, cleared by a mid-stall reset
        stop();
        bus.OUT_wrfull = 1;
        repeat (3) begin
            tick();
            bus.IN_wrreq = 1; bus.IN_data = 8'h77;
        end
        idle(1);
        chk("ovf_set", 32'(OVF), 32'd1);
        pulse_reset();
        chk("ovf_clr", 32'(OVF), 32'd0);
        chk("ovf_rst_req", 32'(bus.OUT_wrreq), 32'd0);
        chk("ovf_rst_full", 32'(bus.IN_wrfull), 32'd0);
        bus.OUT_wrfull = 0;

        // ScreenStop mid-frame with both registers full
        stop();
        wrow(0, 32'h1);
        for (int i = 1; i < 16; i++) wrow(4'(i), 32'h0);
        CUR_COLOR1 = 8'hA5;
        for (int i = 0; i < 5 * H + 100; i++) send(8'h33);
        tick();
        bus.IN_wrreq = 0; bus.OUT_wrfull = 1;
        send(8'h44);
        idle(1);
        chk("ss_full", 32'(bus.IN_wrfull), 32'd1);
        got.delete();
        stop();
        bus.OUT_wrfull = 0;
        idle(3);
        chk("ss_no_stale", 32'(got.size()), 32'd0);
        send(8'h10);
        idle(3);
        chk("ss_count", 32'(got.size()), 32'd1);
        chk("ss_first", 32'(got[0]), 32'hA5);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            tick();
            Reset = $urandom_range(0, 999) == 0;
            ScreenStop = $urandom_range(0, 199) == 0;
            bus.OUT_wrfull = $urandom_range(0, 3) == 0;
            CUR_wren = $urandom_range(0, 15) == 0;
            CUR_wraddress = 4'($urandom);
            CUR_data = $urandom;
            if ($urandom_range(0, 99) == 0) begin
                CUR_X = ($urandom_range(0, 9) == 0) ? 11'd2040 : 11'($urandom_range(0, 250));
                CUR_Y = 11'($urandom_range(0, 3));
                CUR_enable = $urandom_range(0, 3) != 0;
                CUR_COLOR1 = 8'($urandom);
                CUR_COLOR2 = 8'($urandom);
            end
            bus.IN_data = 8'($urandom);
            bus.IN_wrreq = $urandom_range(0, 2) != 0 && (!bus.IN_wrfull || $urandom_range(0, 49) == 0);
        end
        tick();
        Reset = 0; ScreenStop = 0; CUR_wren = 0; bus.OUT_wrfull = 0; bus.IN_wrreq = 0;
        idle(4);
        run = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/cursor_overlay.md
CURSOR_OVERLAY -- requirements
Module: cursor_overlay

Interface
REQ-001 Parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 Parameter V_ACTIVE, default 480, visible lines per frame.
REQ-003 MemClk  in  1  sole clock; all state updates on rising edge.
REQ-004 Reset  in  1  synchronous, active-high reset.
REQ-005 ScreenStop  in  1  frame-restart strobe, already synchronised to MemClk.
REQ-006 IN_data  in  8  palette index from the tiled-mode pixel generator.
REQ-007 IN_wrreq  in  1  upstream write strobe; upstream asserts it only while IN_wrfull=0.
REQ-008 IN_wrfull  out  1  backpressure to upstream.
REQ-009 OUT_data  out  8  palette index toward the Palette stage.
REQ-010 OUT_wrreq  out  1  write strobe toward the Palette stage.
REQ-011 OUT_wrfull  in  1  Palette-stage backpressure.
REQ-012 CUR_enable  in  1  cursor overlay enable.
REQ-013 CUR_X, CUR_Y  in  11 each  cursor top-left pixel position.
REQ-014 CUR_COLOR1, CUR_COLOR2  in  8 each  palette indices for cursor codes 1 and 2.
REQ-015 CUR_wraddress  in  4  bitmap row; CUR_data  in  32  row bits; CUR_wren  in  1  row write strobe.
REQ-016 OVF  out  1  sticky error flag: write while full.

Function
REQ-017 The bitmap SHALL be 16 rows x 32 bits; pixel column c uses bits [2c+1:2c] as its 2-bit code.
REQ-018 A CUR_wren write SHALL take effect on the following cycle; a lookup in the write cycle SHALL use the old row.
REQ-019 Counters X (0..H_ACTIVE-1) and Y (0..V_ACTIVE-1) SHALL tag each accepted input pixel, then advance by one.
REQ-020 X SHALL wrap to 0 after H_ACTIVE-1 with Y+1; after (H_ACTIVE-1, V_ACTIVE-1) both SHALL wrap to 0.
REQ-021 A cursor hit SHALL require CUR_enable=1, CUR_X<=X<CUR_X+16 and CUR_Y<=Y<CUR_Y+16, with sums computed in 12 bits so that there is no wrap; off-screen portions SHALL be clipped.
REQ-022 On a hit with code 0 the pixel SHALL pass unchanged; code 1 SHALL output CUR_COLOR1; code 2 SHALL output CUR_COLOR2; code 3 is defined in REQ-031.
REQ-023 Datapath SHALL be an output register plus one skid register; an accepted pixel SHALL be offered on OUT_wrreq no earlier than the next cycle.
REQ-024 OUT_wrreq SHALL equal (output register valid AND NOT OUT_wrfull); each asserted cycle SHALL consume one pixel.
REQ-025 If the output register is occupied and not draining, an incoming pixel SHALL go to the skid register; IN_wrfull SHALL equal skid valid.
REQ-026 On drain, skid contents SHALL move to the output register in the same cycle; order SHALL be preserved, with no loss and no duplication.
REQ-027 IN_wrreq while IN_wrfull=1 SHALL drop the pixel, SHALL NOT advance X/Y, and SHALL set OVF until Reset.
REQ-028 ScreenStop=1 SHALL clear both registers, force X=Y=0, hold OUT_wrreq=0 and IN_wrfull=0, and ignore IN_wrreq.
REQ-029 The first pixel accepted after ScreenStop falls SHALL be tagged (0,0).

Reset
REQ-030 Reset SHALL clear X, Y, both valid bits, OVF, OUT_data (8'h00), OUT_wrreq, and IN_wrfull in one cycle, including mid-line or mid-stall; bitmap contents SHALL be left unchanged.

Configuration
REQ-031 With macro CURSOR_INVERT_EN defined, code 3 SHALL output IN_data XOR 8'hFF; without it, code 3 SHALL output CUR_COLOR1 and no inversion logic SHALL be built.

Verification
REQ-032 Reset, CUR_enable=0, stream 640 pixels of 0x10 with OUT_wrfull=0 -> 640 outputs of 0x10, first output one cycle after first write.
REQ-033 CUR=(0,0), row0=0x00000001, COLOR1=0xA5, enable=1, stream 0x10 -> output 0xA5 then 0x10, 0x10, ...
REQ-034 CUR_X=632, all rows=0x55555555, COLOR1=0x22 -> lines 0..15 show 0x22 at X 632..639 only; line 16 and X 0..631 unchanged.
REQ-035 Hold OUT_wrfull=1 for 3 cycles during streaming of 1,2,3,4 -> IN_wrfull rises after 2 pixels are held; output sequence 1,2,3,4 exactly; OVF=0.
REQ-036 Hit with code 3 on input 0x0F -> 0xF0 with CURSOR_INVERT_EN; CUR_COLOR1 without it.
REQ-037 Pulse ScreenStop at X=100, Y=5 with both registers full -> no stale outputs; next pixel is overlaid as (0,0) per the row0 bitmap.
